// File: rtl/or_gate_pipe.sv
// Registered bitwise OR with a single-stage valid/ready output register,
// a registered reduction-OR flag on the result and a saturating count of
// accepted transactions.
module or_gate_pipe #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             y_any,
    output logic [CNT_W-1:0] txn_count
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [WIDTH-1:0] y_q, y_d;
    logic             y_any_q, y_any_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    // The stage is free when empty or when its current result leaves this cycle.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Next-state: load on accept (covers simultaneous drain), else drain clears valid.
    always_comb begin
        y_d     = y_q;
        y_any_d = y_any_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (accept) begin
            y_d     = A | B;
            y_any_d = |(A | B);
            valid_d = 1'b1;
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // State register with synchronous active-low reset overriding any handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q     <= '0;
            y_any_q <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            y_q     <= y_d;
            y_any_q <= y_any_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Y         = y_q;
    assign y_any     = y_any_q;
    assign out_valid = valid_q;
    assign txn_count = cnt_q;

endmodule

// File: tb/tb_or_gate_pipe.sv
// Scoreboard bench for or_gate_pipe: two instances (WIDTH=1/CNT_W=8 and
// WIDTH=8/CNT_W=2) share the handshake; expected results are queued on accept
// and compared when the result is consumed.
module tb_or_gate_pipe;

    typedef struct {
        logic [7:0] y8;
        logic       any8;
        logic       y1;
        logic       any1;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a_in, b_in;
    logic       in_valid, out_ready;

    logic       rdy1, ov1, any1;
    logic [0:0] y1;
    logic [7:0] cnt1;
    logic       rdy8, ov8, any8;
    logic [7:0] y8;
    logic [1:0] cnt8;

    exp_t       sb[$];
    exp_t       last;
    int         exp_cnt1, exp_cnt8;
    int         n_checks = 0;
    int         n_fail   = 0;

    or_gate_pipe #(.WIDTH(1), .CNT_W(8)) u_dut_w1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (a_in[0:0]),
        .B         (b_in[0:0]),
        .in_valid  (in_valid),
        .in_ready  (rdy1),
        .Y         (y1),
        .out_valid (ov1),
        .out_ready (out_ready),
        .y_any     (any1),
        .txn_count (cnt1)
    );

    or_gate_pipe #(.WIDTH(8), .CNT_W(2)) u_dut_w8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (a_in),
        .B         (b_in),
        .in_valid  (in_valid),
        .in_ready  (rdy8),
        .Y         (y8),
        .out_valid (ov8),
        .out_ready (out_ready),
        .y_any     (any8),
        .txn_count (cnt8)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        sb.delete();
        last     = '{y8: 8'h00, any8: 1'b0, y1: 1'b0, any1: 1'b0};
        exp_cnt1 = 0;
        exp_cnt8 = 0;
    endtask

    // One clock cycle: drive, check at negedge, update the model, pass the edge.
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic v,
                        input logic r);
        logic exp_ready;
        exp_t e;
        a_in      = a;
        b_in      = b;
        in_valid  = v;
        out_ready = r;
        @(negedge clk);
        exp_ready = (sb.size() == 0) || r;
        check_eq("w1_out_valid", 32'(ov1), 32'(sb.size() != 0));
        check_eq("w8_out_valid", 32'(ov8), 32'(sb.size() != 0));
        check_eq("w1_in_ready", 32'(rdy1), 32'(exp_ready));
        check_eq("w8_in_ready", 32'(rdy8), 32'(exp_ready));
        check_eq("w1_y_held", 32'(y1), 32'(last.y1));
        check_eq("w8_y_held", 32'(y8), 32'(last.y8));
        check_eq("w1_y_any", 32'(any1), 32'(last.any1));
        check_eq("w8_y_any", 32'(any8), 32'(last.any8));
        check_eq("w1_txn_count", 32'(cnt1), 32'(exp_cnt1));
        check_eq("w8_txn_count", 32'(cnt8), 32'(exp_cnt8));
        if (sb.size() != 0 && r) begin
            e = sb.pop_front();
            check_eq("w1_y_consumed", 32'(y1), 32'(e.y1));
            check_eq("w8_y_consumed", 32'(y8), 32'(e.y8));
        end
        if (v && exp_ready) begin
            e.y8   = a | b;
            e.any8 = (a | b) != 8'h00;
            e.y1   = a[0] | b[0];
            e.any1 = a[0] | b[0];
            sb.push_back(e);
            last = e;
            if (exp_cnt1 < 255) exp_cnt1++;
            if (exp_cnt8 < 3) exp_cnt8++;
        end
        @(posedge clk);
        #1;
    endtask

    // Reset asserted during an attempted accept; reset must win.
    task automatic do_reset(input logic [7:0] a, input logic [7:0] b);
        a_in      = a;
        b_in      = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model();
    endtask

    initial begin
        rst_n     = 1'b0;
        a_in      = 8'h00;
        b_in      = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        do_reset(8'hFF, 8'hFF);

        // Reset state, then the 1-bit truth table at full throughput.
        step(8'h00, 8'h00, 1'b0, 1'b1);
        step(8'h00, 8'h00, 1'b1, 1'b1);
        step(8'h00, 8'h01, 1'b1, 1'b1);
        step(8'h01, 8'h00, 1'b1, 1'b1);
        step(8'h01, 8'h01, 1'b1, 1'b1);
        step(8'h00, 8'h00, 1'b0, 1'b1);  // drain: Y holds, out_valid falls
        step(8'h00, 8'h00, 1'b0, 1'b1);

        // Wide operands.
        step(8'hA5, 8'h0F, 1'b1, 1'b1);
        step(8'h00, 8'h00, 1'b1, 1'b1);
        step(8'h00, 8'h00, 1'b0, 1'b1);

        // Back-pressure: result 1 pending, new operands stall for 3 cycles.
        step(8'h01, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(8'h00, 8'h00, 1'b1, 1'b0);
        step(8'h00, 8'h00, 1'b1, 1'b1);  // drain and accept together
        step(8'h00, 8'h00, 1'b0, 1'b0);
        step(8'h00, 8'h00, 1'b0, 1'b1);
        step(8'h00, 8'h00, 1'b0, 1'b1);

        // Random traffic exercises both counters well past saturation of the 2-bit one.
        for (int i = 0; i < 60; i++) begin
            step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset mid-transfer with a held result.
        do_reset(8'h00, 8'h00);
        step(8'h3C, 8'h00, 1'b1, 1'b0);
        do_reset(8'hF0, 8'h0F);
        step(8'h00, 8'h00, 1'b0, 1'b0);
        step(8'h00, 8'h00, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/or_gate_pipe.md
Name: or_gate_pipe

Overview:
- Registered bitwise OR unit: Y = A | B, delivered through a single-stage pipeline register with a valid/ready handshake.
- Sits between a stimulus/interface bundle and downstream consumers as the leaf logic-function block.
- Also provides a reduction-OR flag on the result and a saturating count of accepted transactions for debug.

Parameters:
- WIDTH, 1, bit width of operands A, B and result Y.
- CNT_W, 8, width of the accepted-transaction counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- in_valid  input  1  A/B are valid this cycle.
- in_ready  output  1  block can accept A/B this cycle.
- Y  output  WIDTH  registered result A | B.
- out_valid  output  1  Y holds an unconsumed result.
- out_ready  input  1  downstream accepts Y this cycle.
- y_any  output  1  registered reduction OR of Y, updated together with Y.
- txn_count  output  CNT_W  number of accepted input transactions, saturating.

Behaviour:
- Reset: when rst_n=0 at a clk edge, Y=0, y_any=0, out_valid=0 and txn_count=0. Reset overrides any simultaneous handshake. A reset mid-transfer discards the held result.
- in_ready is combinational: in_ready = !out_valid || out_ready. No other combinational path runs from inputs to outputs.
- Accept: in_valid && in_ready at a clk edge:
  - Y <= A | B (bitwise, WIDTH bits, no carry, no extension).
  - y_any <= |(A | B).
  - out_valid <= 1.
- Latency: exactly 1 cycle from accept to out_valid=1 with the new Y.
- Drain: out_valid && out_ready with no accept in the same cycle -> out_valid <= 0. Y and y_any hold their last values.
- Simultaneous drain and accept in one cycle:
  - The old Y is consumed.
  - The new result is loaded.
  - out_valid stays 1.
  - Full throughput is 1 result per cycle.
- Stall: out_valid=1 and out_ready=0 forces in_ready=0.
  - Y, y_any and out_valid hold.
  - in_valid is ignored and no data is lost.
- in_valid=0: no state change except the drain rule above.
- txn_count increments by 1 on each accept. It saturates at 2^CNT_W-1 and does not wrap. Only reset clears it.
- X/undefined operands are not filtered; Y follows the OR truth table bitwise.

Test Plan:
- Reset, then hold out_ready=1 and apply {A,B} = 00, 01, 10, 11 on consecutive cycles with in_valid=1 -> one cycle later, Y = 0, 1, 1, 1 and y_any = 0, 1, 1, 1. out_valid=1 from the cycle after the first accept. txn_count = 4.
- WIDTH=8, A=8'hA5, B=8'h0F accepted -> Y=8'hAF, y_any=1. Then A=8'h00, B=8'h00 -> Y=8'h00, y_any=0.
- Back-pressure: result Y=1 pending with out_ready=0, then drive A=0, B=0, in_valid=1 for 3 cycles -> in_ready=0, Y stays 1, txn_count unchanged. Raise out_ready -> the new operands are accepted in that same cycle and Y=0 on the next.
- Drain with no new input: out_valid=1, out_ready=1, in_valid=0 -> out_valid=0 next cycle, Y holds its value.
- Counter saturation: CNT_W=2, 6 accepts -> txn_count sequence 1, 2, 3, 3, 3, 3.
- Reset mid-operation: rst_n=0 during an accept with out_valid=1 -> next cycle Y=0, y_any=0, out_valid=0, txn_count=0, and in_ready=1 once rst_n=1.
